// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU front end.
package cpu_pkg;

    localparam int PC_WIDTH       = 9;
    localparam int INSTR_WIDTH    = 16;
    localparam int CODE_MEM_DEPTH = 1 << PC_WIDTH;

    // Fetch sequencer states: issue an address, wait out the memory latency,
    // then hold the instruction until control_unit reports it executed.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_program_counter.sv
// Program counter register: loadable, incrementing, wraps modulo 2^WIDTH.
module program_counter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Next PC: a jump load overrides the sequential increment.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_value;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // PC register with synchronous reset to address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign out = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one fetch in flight, IR handed to control_unit
// through a valid/done handshake, jump loads accepted while holding.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter int MEM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    out_code_mem_addr,
    input  logic [INSTR_WIDTH-1:0] in_code_mem_data,
    output logic [INSTR_WIDTH-1:0] out_ir,
    output logic                   out_ir_valid,
    input  logic                   in_instr_done,
    input  logic                   in_pc_load,
    input  logic [PC_WIDTH-1:0]    in_pc_load_value,
    input  logic                   in_stall,
    output logic [PC_WIDTH-1:0]    out_pc
);

    // Latency is 1..3, so a 2-bit down-counter covers every wait.
    localparam logic [1:0] WAIT_INIT = 2'(MEM_LATENCY - 1);

    fetch_state_t           state_q, state_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   valid_q, valid_d;
    logic [PC_WIDTH-1:0]    fetch_addr_q, fetch_addr_d;
    logic [1:0]             wait_cnt_q, wait_cnt_d;
    logic                   pc_inc;
    logic                   pc_load;
    logic [PC_WIDTH-1:0]    pc;

    program_counter #(
        .WIDTH(PC_WIDTH)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_value(in_pc_load_value),
        .out       (pc)
    );

    // Fetch sequencer next-state logic.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        valid_d      = valid_q;
        fetch_addr_d = fetch_addr_q;
        wait_cnt_d   = wait_cnt_q;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        case (state_q)
            ISSUE: begin
                if (!in_stall) begin
                    fetch_addr_d = pc;
                    wait_cnt_d   = WAIT_INIT;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                // Stall and jump requests are deliberately not looked at here.
                if (wait_cnt_q != 2'd0) begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end else begin
                    ir_d    = in_code_mem_data;
                    pc_inc  = 1'b1;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A load in the same cycle as done steers the next fetch.
                pc_load = in_pc_load;
                if (in_instr_done) begin
                    valid_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = ISSUE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer registers; reset drops any in-flight or held instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ISSUE;
            ir_q         <= '0;
            valid_q      <= 1'b0;
            fetch_addr_q <= '0;
            wait_cnt_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            valid_q      <= valid_d;
            fetch_addr_q <= fetch_addr_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign out_code_mem_addr = fetch_addr_q;
    assign out_ir            = ir_q;
    assign out_ir_valid      = valid_q;
    assign out_pc            = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-1 instance driven by scenario tasks with a
// scoreboard of expected fetches, plus a latency-3 instance for mid-fetch reset.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] ir;
        logic [8:0]  pc;
    } exp_t;

    exp_t sb_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    logic [15:0] mem [0:511];

    function automatic logic [15:0] mval(input int a);
        logic [15:0] v;
        if (a == 0)      v = 16'h1234;
        else if (a == 1) v = 16'hABCD;
        else             v = 16'(a * 257) ^ 16'h3C00;
        return v;
    endfunction

    // ---------------- latency-1 instance ----------------
    logic        rst = 1'b1, done = 1'b0, load = 1'b0, stall = 1'b0;
    logic [8:0]  load_val = '0;
    logic [8:0]  addr, pc;
    logic [15:0] mem_data, ir;
    logic        valid;

    assign mem_data = mem[addr];

    fetch_unit #(.PC_WIDTH(9), .INSTR_WIDTH(16), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .out_code_mem_addr(addr), .in_code_mem_data(mem_data),
        .out_ir(ir), .out_ir_valid(valid), .in_instr_done(done),
        .in_pc_load(load), .in_pc_load_value(load_val),
        .in_stall(stall), .out_pc(pc)
    );

    // ---------------- latency-3 instance ----------------
    logic        rst3 = 1'b1, done3 = 1'b0, load3 = 1'b0, stall3 = 1'b0;
    logic [8:0]  load_val3 = '0;
    logic [8:0]  addr3, pc3;
    logic [15:0] mem_p1, mem_p2, ir3;
    logic        valid3;

    always @(posedge clk) begin
        mem_p1 <= mem[addr3];
        mem_p2 <= mem_p1;
    end

    fetch_unit #(.PC_WIDTH(9), .INSTR_WIDTH(16), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3),
        .out_code_mem_addr(addr3), .in_code_mem_data(mem_p2),
        .out_ir(ir3), .out_ir_valid(valid3), .in_instr_done(done3),
        .in_pc_load(load3), .in_pc_load_value(load_val3),
        .in_stall(stall3), .out_pc(pc3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int a, input int next_pc);
        exp_t e;
        e.addr = 9'(a);
        e.ir   = mval(a);
        e.pc   = 9'(next_pc);
        sb_q.push_back(e);
    endtask

    // Scoreboard: each rising out_ir_valid must match the oldest expected fetch.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            checks_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL scoreboard_unexpected: got ir=%h pc=%h addr=%h, required no fetch", ir, pc, addr);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({ir, pc, addr} !== {e.ir, e.pc, e.addr})
                    $display("FAIL scoreboard: got ir=%h pc=%h addr=%h, required ir=%h pc=%h addr=%h",
                             ir, pc, addr, e.ir, e.pc, e.addr);
                else begin
                    checks_passed++;
                    $display("fetch addr=%h ir=%h next_pc=%h ok", addr, ir, pc);
                end
            end
        end
        prev_valid <= valid;
    end

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        checks_total++;
        if ({pc, ir, valid, addr} !== {9'd0, 16'd0, 1'b0, 9'd0})
            $display("FAIL reset_state: got pc=%h ir=%h valid=%b addr=%h, required 0/0/0/0", pc, ir, valid, addr);
        else checks_passed++;
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        push_exp(0, 1);
        tick;
        checks_total++;
        if ({addr, valid} !== {9'd0, 1'b0})
            $display("FAIL seq_issue: got addr=%h valid=%b, required addr=000 valid=0", addr, valid);
        else checks_passed++;
        tick;
        checks_total++;
        if ({valid, ir, pc} !== {1'b1, 16'h1234, 9'd1})
            $display("FAIL seq_first: got valid=%b ir=%h pc=%h, required 1/1234/001", valid, ir, pc);
        else checks_passed++;
        done = 1'b1; push_exp(1, 2);
        tick; done = 1'b0;
        checks_total++;
        if (valid !== 1'b0)
            $display("FAIL seq_done_clear: got valid=%b, required 0", valid);
        else checks_passed++;
        tick; tick;
        checks_total++;
        if ({valid, ir, pc} !== {1'b1, 16'hABCD, 9'd2})
            $display("FAIL seq_second: got valid=%b ir=%h pc=%h, required 1/abcd/002", valid, ir, pc);
        else checks_passed++;
    endtask

    task automatic test_jump;
        for (int k = 2; k <= 4; k++) begin
            done = 1'b1; push_exp(k, k + 1);
            tick; done = 1'b0;
            tick; tick;
        end
        checks_total++;
        if ({valid, pc} !== {1'b1, 9'd5})
            $display("FAIL jump_pre_pc: got valid=%b pc=%h, required 1/005", valid, pc);
        else checks_passed++;
        load = 1'b1; load_val = 9'h055;
        tick;
        checks_total++;
        if ({valid, pc} !== {1'b1, 9'h055})
            $display("FAIL jump_hold_load: got valid=%b pc=%h, required 1/055", valid, pc);
        else checks_passed++;
        load_val = 9'h1F0; done = 1'b1; push_exp(9'h1F0, 9'h1F1);
        tick; load = 1'b0; done = 1'b0;
        checks_total++;
        if ({valid, pc} !== {1'b0, 9'h1F0})
            $display("FAIL jump_last_wins: got valid=%b pc=%h, required 0/1f0", valid, pc);
        else checks_passed++;
        tick;
        checks_total++;
        if (addr !== 9'h1F0)
            $display("FAIL jump_addr: got addr=%h, required 1f0", addr);
        else checks_passed++;
        tick;
        checks_total++;
        if ({valid, ir, pc} !== {1'b1, mval(9'h1F0), 9'h1F1})
            $display("FAIL jump_fetch: got valid=%b ir=%h pc=%h, required 1/%h/1f1", valid, ir, pc, mval(9'h1F0));
        else checks_passed++;
    endtask

    task automatic test_wrap;
        load = 1'b1; load_val = 9'h1FF; done = 1'b1; push_exp(511, 0);
        tick; load = 1'b0; done = 1'b0;
        tick; tick;
        checks_total++;
        if ({valid, ir, pc} !== {1'b1, mval(511), 9'd0})
            $display("FAIL wrap_fetch: got valid=%b ir=%h pc=%h, required 1/%h/000", valid, ir, pc, mval(511));
        else checks_passed++;
        done = 1'b1; push_exp(0, 1);
        tick; done = 1'b0;
        tick;
        checks_total++;
        if (addr !== 9'd0)
            $display("FAIL wrap_next_addr: got addr=%h, required 000", addr);
        else checks_passed++;
        tick;
    endtask

    task automatic test_stall;
        stall = 1'b1; done = 1'b1;
        tick; done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks_total++;
            if ({valid, pc, addr} !== {1'b0, 9'd1, 9'd0})
                $display("FAIL stall_hold_%0d: got valid=%b pc=%h addr=%h, required 0/001/000", c, valid, pc, addr);
            else checks_passed++;
        end
        stall = 1'b0; push_exp(1, 2);
        tick;
        checks_total++;
        if ({valid, addr} !== {1'b0, 9'd1})
            $display("FAIL stall_release_issue: got valid=%b addr=%h, required 0/001", valid, addr);
        else checks_passed++;
        stall = 1'b1;
        tick;
        checks_total++;
        if ({valid, ir} !== {1'b1, mval(1)})
            $display("FAIL stall_in_wait: got valid=%b ir=%h, required 1/%h", valid, ir, mval(1));
        else checks_passed++;
        stall = 1'b0;
    endtask

    task automatic test_ignored;
        done = 1'b1;
        tick; done = 1'b0;
        stall = 1'b1; done = 1'b1; load = 1'b1; load_val = 9'h0AA;
        tick;
        checks_total++;
        if ({valid, pc, addr} !== {1'b0, 9'd2, 9'd1})
            $display("FAIL ignore_issue: got valid=%b pc=%h addr=%h, required 0/002/001", valid, pc, addr);
        else checks_passed++;
        stall = 1'b0; done = 1'b0; push_exp(2, 3);
        tick;
        checks_total++;
        if ({addr, pc} !== {9'd2, 9'd2})
            $display("FAIL ignore_load_issue: got addr=%h pc=%h, required 002/002", addr, pc);
        else checks_passed++;
        tick; load = 1'b0;
        checks_total++;
        if ({valid, ir, pc} !== {1'b1, mval(2), 9'd3})
            $display("FAIL ignore_load_wait: got valid=%b ir=%h pc=%h, required 1/%h/003", valid, ir, pc, mval(2));
        else checks_passed++;
    endtask

    task automatic test_reset_mid_wait;
        rst3 = 1'b1;
        tick; tick; rst3 = 1'b0;
        tick; tick; tick;
        checks_total++;
        if (valid3 !== 1'b0)
            $display("FAIL lat3_early: got valid=%b, required 0", valid3);
        else checks_passed++;
        tick;
        checks_total++;
        if ({valid3, ir3, pc3} !== {1'b1, mval(0), 9'd1})
            $display("FAIL lat3_fetch: got valid=%b ir=%h pc=%h, required 1/%h/001", valid3, ir3, pc3, mval(0));
        else checks_passed++;
        load3 = 1'b1; load_val3 = 9'h100; done3 = 1'b1;
        tick; load3 = 1'b0; done3 = 1'b0;
        tick; tick;
        rst3 = 1'b1;
        tick; rst3 = 1'b0;
        checks_total++;
        if ({pc3, valid3, ir3, dut3.state_q} !== {9'd0, 1'b0, 16'd0, ISSUE})
            $display("FAIL mid_wait_reset: got pc=%h valid=%b ir=%h state=%0d, required 000/0/0000/ISSUE",
                     pc3, valid3, ir3, dut3.state_q);
        else checks_passed++;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks_total++;
            if ({valid3, ir3} !== {1'b0, 16'd0})
                $display("FAIL no_stale_%0d: got valid=%b ir=%h, required 0/0000", c, valid3, ir3);
            else checks_passed++;
        end
        tick;
        checks_total++;
        if ({valid3, ir3, pc3} !== {1'b1, mval(0), 9'd1})
            $display("FAIL refetch_after_reset: got valid=%b ir=%h pc=%h, required 1/%h/001", valid3, ir3, pc3, mval(0));
        else checks_passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = mval(i);
        test_reset();
        test_sequential();
        test_jump();
        test_wrap();
        test_stall();
        test_ignored();
        test_reset_mid_wait();
        tick; tick;
        checks_total++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        else checks_passed++;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
